// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory read port, branch redirect and the
// valid/ready instruction handoff to the controller.
interface fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             fetch_en;
  logic [15:0]      im_addr;
  logic [31:0]      im_data;
  logic             redirect;
  logic [15:0]      redirect_addr;
  logic             ir_ready;
  logic             ir_valid;
  logic [31:0]      ir;
  logic [15:0]      ir_pc;
  logic [15:0]      ir_pc_inc;
  logic [PTR_W:0]   count;

  // master = core/memory environment, slave = the fetch queue itself
  modport master (
    output fetch_en, im_data, redirect, redirect_addr, ir_ready,
    input  im_addr, ir_valid, ir, ir_pc, ir_pc_inc, count
  );

  modport slave (
    input  fetch_en, im_data, redirect, redirect_addr, ir_ready,
    output im_addr, ir_valid, ir, ir_pc, ir_pc_inc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO: a word fetched at edge N is visible on ir after N (one-cycle redirect bubble).
// Full queue stalls fetch_pc unless the head is consumed in the same cycle; redirect flushes everything.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          CLK,
  input  logic          RST_F,
  fetch_queue_if.slave  fq
);

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] dat;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  entry_t             mem_q [DEPTH];
  logic [15:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               vld;
  logic               pop;
  logic               push;
  entry_t             head;

  assign vld  = (count_q != '0);
  assign pop  = vld & fq.ir_ready;
  // A full queue may still accept a word when the head leaves this cycle
  assign push = fq.fetch_en & ~fq.redirect & ((count_q != FULL_CNT) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (fq.redirect) begin
      fetch_pc_d = fq.redirect_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is qualified by count, so it is left unreset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fetch_pc_q, fq.im_data};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign fq.im_addr   = fetch_pc_q;
  assign fq.ir_valid  = vld;
  assign fq.count     = count_q;
  assign fq.ir        = vld ? head.dat : 32'h0;
  assign fq.ir_pc     = vld ? head.pc : 16'h0;
  assign fq.ir_pc_inc = vld ? (head.pc + 16'd1) : 16'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random traffic.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_f = 1'b0;

  fetch_queue_if #(.PTR_W(PTR_W)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK   (clk),
    .RST_F (rst_f),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h1000_0001 + {16'h0, a};
  endfunction

  assign fq.im_data = mem_word(fq.im_addr);

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  int          mcount   = 0;
  logic [15:0] mpc      = 16'h0;
  bit          m_pop, m_push;
  exp_t        mon_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue occupancy and fetch address from the rules
  always @(posedge clk) begin
    if (rst_f) begin
      m_pop = (mcount != 0) && fq.ir_ready;
      if (fq.redirect) begin
        sb_q.delete();
        mcount = 0;
        mpc    = fq.redirect_addr;
      end else begin
        m_push = fq.fetch_en && ((mcount < DEPTH) || m_pop);
        if (m_push) begin
          sb_q.push_back('{pc: mpc, dat: mem_word(mpc)});
          mpc = mpc + 16'd1;
        end
        mcount = mcount + int'(m_push) - int'(m_pop);
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle; consume expected entries on handshake
  always @(negedge clk) begin
    chk("count", 32'(fq.count), 32'(mcount));
    chk("ir_valid", 32'(fq.ir_valid), 32'(mcount != 0));
    chk("im_addr", 32'(fq.im_addr), 32'(mpc));
    if (fq.ir_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=valid required=no_entry t=%0t", $time);
      end else begin
        mon_head = sb_q[0];
        chk("ir", fq.ir, mon_head.dat);
        chk("ir_pc", 32'(fq.ir_pc), 32'(mon_head.pc));
        chk("ir_pc_inc", 32'(fq.ir_pc_inc), 32'(16'(mon_head.pc + 16'd1)));
        if (fq.ir_ready) void'(sb_q.pop_front());
      end
    end else begin
      chk("ir_empty", fq.ir, 32'h0);
      chk("ir_pc_empty", 32'(fq.ir_pc), 32'h0);
      chk("ir_pc_inc_empty", 32'(fq.ir_pc_inc), 32'h0);
    end
  end

  task automatic cyc(input bit fe, input bit rdy, input bit rd, input logic [15:0] ra);
    fq.fetch_en      = fe;
    fq.ir_ready      = rdy;
    fq.redirect      = rd;
    fq.redirect_addr = ra;
    @(posedge clk);
    #2;
  endtask

  initial begin
    fq.fetch_en      = 1'b0;
    fq.ir_ready      = 1'b0;
    fq.redirect      = 1'b0;
    fq.redirect_addr = 16'h0;
    #2 rst_f = 1'b1;

    // fill from reset, then one stalled cycle at full
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 16'h0);
    // full queue streaming: pop and push every cycle
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0);
    // drop to three entries, redirect with a simultaneous pop
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 16'h0020);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    // address wrap across 16'hFFFF and stall at full
    cyc(1'b1, 1'b0, 1'b1, 16'hFFFE);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 16'h0);
    // drain with fetch disabled, then try to underflow
    repeat (6) cyc(1'b0, 1'b1, 1'b0, 16'h0);
    // three entries, then asynchronous reset between edges
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0);
    rst_f = 1'b0;
    sb_q.delete();
    mcount = 0;
    mpc    = 16'h0;
    #1;
    chk("async_rst_ir_valid", 32'(fq.ir_valid), 32'h0);
    chk("async_rst_count", 32'(fq.count), 32'h0);
    chk("async_rst_im_addr", 32'(fq.im_addr), 32'h0);
    #1;
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    rst_f = 1'b1;

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0,
          ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom));
    end
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage between the instruction memory and the instruction register/decode path of the sisc core.
- Drives the instruction-memory read address and captures the 32-bit words returned into a small FIFO.
- Presents the oldest buffered instruction and its address to the controller with a valid/ready handshake.
- Flushes and restarts fetching on a branch redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_F  input  1  asynchronous, active-low reset.
- fetch_en  input  1  allows new fetches when 1; the queue still drains when 0.
- im_addr  output  16  instruction-memory read address; equals internal fetch_pc.
- im_data  input  32  combinational instruction-memory read data for im_addr.
- redirect  input  1  branch taken; flush the queue and restart fetching at redirect_addr.
- redirect_addr  input  16  branch target address.
- ir_ready  input  1  consumer accepts the head entry this cycle.
- ir_valid  output  1  head entry is valid.
- ir  output  32  head instruction; 32'h0 when the queue is empty.
- ir_pc  output  16  address of the head instruction; 16'h0 when the queue is empty.
- ir_pc_inc  output  16  ir_pc + 1, modulo 2^16; 16'h0 when the queue is empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (asynchronous, RST_F=0):
  - fetch_pc=0, rd_ptr=0, wr_ptr=0, count=0.
  - Outputs: ir_valid=0, ir=0, ir_pc=0, ir_pc_inc=0, im_addr=0.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation discards all entries immediately.
- pop = ir_valid & ir_ready.
- push = fetch_en & ~redirect & (count<DEPTH | pop).
  - Pushing into a full queue is allowed only when a pop occurs in the same cycle.
- On a push edge:
  - Store {fetch_pc, im_data} at wr_ptr.
  - wr_ptr++ (wraps modulo DEPTH).
  - fetch_pc++ (wraps 16'hFFFF -> 16'h0000).
- On a pop edge: rd_ptr++ (wraps modulo DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Redirect has priority over push and pop. On a redirect edge:
  - rd_ptr=wr_ptr=0, count=0, fetch_pc=redirect_addr.
  - Any simultaneous pop is still considered consumed, but no state beyond the flush changes.
- Latency:
  - A word fetched at edge N appears at ir with ir_valid=1 after edge N; the ir path is combinational from storage.
  - After a redirect at edge N, the first fetch at redirect_addr is pushed at edge N+1, so ir_valid=1 after N+1.
  - Redirect-to-valid bubble is exactly one cycle.
- Outputs:
  - ir_valid = (count != 0).
  - ir, ir_pc, ir_pc_inc are driven from the head entry when valid, zero otherwise.
- Empty queue with ir_ready=1: no pop, no underflow; count stays 0.
- Full queue, ir_ready=0: no push; fetch_pc holds; im_addr stable.
- fetch_en=0: fetch_pc holds; the queue drains normally.
- Ordering: strict FIFO; ir_pc values of consecutive pops increment by 1 except across a redirect.

Test Plan:
- Reset release, im holds 0x10000001..0x10000004 at addresses 0..3, ir_ready=0:
  - Required: count reaches 4 after 4 edges.
  - Required: im_addr holds 4.
  - Required: ir=0x10000001, ir_pc=0.
- Full queue, then ir_ready=1 for 4 cycles:
  - Required: pops return ir_pc 0,1,2,3 in order.
  - Required: simultaneous pushes of addresses 4,5,6,7 keep count=4.
- Redirect to 0x0020 while count=3 and ir_ready=1:
  - Required: next cycle count=0, ir_valid=0, ir=0.
  - Required: one cycle later ir_pc=0x0020, ir_pc_inc=0x0021, ir_valid=1.
- Redirect to 0xFFFE with ir_ready=0:
  - Required: entries are fetched with ir_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Required: im_addr wraps to 0x0000, then stops at 0x0002 when full.
- fetch_en=0 with 2 entries and ir_ready=1:
  - Required: queue drains to count=0 in 2 cycles; im_addr unchanged.
  - Required: further ir_ready=1 leaves count=0 with no underflow.
- RST_F pulsed low between edges with count=3:
  - Required: ir_valid=0 and count=0 immediately, without waiting for CLK.
  - Required: im_addr=0.
